sram_port_arbiter: RTL and testbench
====================================

// Module: sram_port_arbiter
// PURPOSE
//  Two-requester arbiter/sequencer for the single-port 8 KiB track-buffer SRAM (13-bit addr, 8-bit data,
//  registered read output that is 8'bz when not reading). Sits between the SRAM and its two masters:
//  port 0 = floppy bitstream engine, port 1 = host/config loader. It serialises accesses, drives the
//  SRAM control lines and captures read data on the one cycle it is valid.
// PARAMETERS
//  ADDR_W      13  SRAM address width
//  DATA_W      8   SRAM data width
//  FIXED_PRIO  0   0 = round-robin between ports; 1 = port 0 always wins a contested grant
// PORTS
//  clk          in   1       system clock, all logic on posedge
//  rst          in   1       asynchronous, active-high reset
//  req0/req1    in   1       access request, level; held until ackN
//  we0/we1      in   1       1 = write, 0 = read; stable while reqN high
//  addr0/addr1  in   ADDR_W  access address; stable while reqN high
//  wdata0/1     in   DATA_W  write data; stable while reqN high
//  ack0/ack1    out  1       one-cycle completion pulse
//  rdata0/1     out  DATA_W  read result, valid with ackN, held until next read on that port
//  busy         out  1       1 whenever state != IDLE
//  sram_addr    out  ADDR_W  to SRAM addr
//  sram_wdata   out  DATA_W  to SRAM data_in
//  sram_rw      out  1       to SRAM rw (1 = read, 0 = write)
//  sram_en      out  1       to SRAM en
//  sram_rdata   in   DATA_W  from SRAM data_out (registered, 1-cycle latency, z when idle)
// BEHAVIOUR
//  - All outputs registered. Reset (async, any time): state=IDLE, ack0/1=0, rdata0/1=0, busy=0,
//    sram_en=0, sram_rw=1, sram_addr=0, sram_wdata=0, rr pointer favours port 0 first.
//  - FSM states IDLE, ACCESS, CAPTURE.
//  - IDLE: eligible_N = reqN & ~ackN (port just acked is masked this cycle). None eligible -> stay.
//    One eligible -> grant it. Both -> FIXED_PRIO=1: port 0; else port != last granted.
//    On grant: latch port id, sram_addr<=addrN, sram_wdata<=wdataN, sram_rw<=~weN, sram_en<=1,
//    last_grant<=N, -> ACCESS.
//  - ACCESS (sram_en high this cycle; SRAM acts on closing edge): sram_en<=0, sram_rw<=1.
//    Write: ackN<=1, -> IDLE. Read: -> CAPTURE.
//  - CAPTURE (sram_rdata valid this cycle): rdataN<=sram_rdata, ackN<=1, -> IDLE.
//  - ack is a single-cycle pulse; cleared on the next edge unconditionally.
//  - Latency from req sampled high in IDLE: write ack 2 cycles, read ack 3 cycles.
//    Peak throughput: 1 write / 2 clk, 1 read / 3 clk.
//  - A requester keeping reqN high through ackN issues a new access; it updates we/addr/wdata on the
//    edge closing the ack cycle. The masking rule guarantees the other port is granted in between
//    when it is waiting (round-robin) -> no starvation in mode 0.
//  - sram_rdata is ignored outside CAPTURE (z values never reach rdataN).
//  - reqN dropped before ackN: the access already granted completes and acks anyway; requester must
//    ignore it. Changing addr/we/wdata while reqN high is illegal; arbiter uses values latched at grant.
//  - sram_addr wraps only by address width; no range checks.
//  - Reset mid-ACCESS: sram_en falls immediately; an in-flight write may or may not have landed;
//    no ack is issued.
// TESTING
//  1. Port0 write 0x1FFF<=0xA5, then port0 read 0x1FFF -> ack0 at +2 clk, then ack0 at +3 clk with rdata0=0xA5.
//  2. req0 and req1 reads asserted same cycle, both held, RR mode -> grants alternate 0,1,0,1; each ack pulses 1 cycle.
//  3. FIXED_PRIO=1, req0 held continuously, req1 held -> port1 served only in the IDLE cycle port0 is masked; check no deadlock.
//  4. Write 0x0000<=0x3C via port1, read 0x0000 via port0 -> rdata0=0x3C, rdata1 unchanged.
//  5. Assert rst during ACCESS of a write -> sram_en=0 and ack=0 same cycle; after release, idle and busy=0.
//  6. Idle with no req for 20 cycles -> sram_en stays 0, rdata0/1 hold last values despite sram_rdata=z.

Source files
------------

// File: rtl/sram_port_arbiter_if.sv
// Requester-side bundle for the track-buffer SRAM arbiter.
// Port 0 is the floppy bitstream engine; port 1 is the host/config loader.
interface sram_port_arbiter_if #(
  parameter int ADDR_W = 13,
  parameter int DATA_W = 8
);
  logic              req0;
  logic              req1;
  logic              we0;
  logic              we1;
  logic [ADDR_W-1:0] addr0;
  logic [ADDR_W-1:0] addr1;
  logic [DATA_W-1:0] wdata0;
  logic [DATA_W-1:0] wdata1;
  logic              ack0;
  logic              ack1;
  logic [DATA_W-1:0] rdata0;
  logic [DATA_W-1:0] rdata1;

  modport master (
    output req0, req1, we0, we1,
    output addr0, addr1, wdata0, wdata1,
    input  ack0, ack1, rdata0, rdata1
  );

  modport slave (
    input  req0, req1, we0, we1,
    input  addr0, addr1, wdata0, wdata1,
    output ack0, ack1, rdata0, rdata1
  );
endinterface

// File: rtl/sram_port_arbiter.sv
// Two-port arbiter/sequencer for the single-port track-buffer SRAM.
// Serialises accesses, drives SRAM control and captures registered read data.
module sram_port_arbiter #(
  parameter int ADDR_W     = 13,
  parameter int DATA_W     = 8,
  parameter int FIXED_PRIO = 0
) (
  input  logic              clk,
  input  logic              rst,
  sram_port_arbiter_if.slave bus,
  output logic              busy_o,
  output logic [ADDR_W-1:0] sram_addr_o,
  output logic [DATA_W-1:0] sram_wdata_o,
  output logic              sram_rw_o,
  output logic              sram_en_o,
  input  logic [DATA_W-1:0] sram_rdata_i
);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    CAPTURE
  } state_e;

  localparam bit RoundRobin = (FIXED_PRIO == 0);

  state_e            state_q, state_d;
  logic              port_q, port_d;
  logic              last_q, last_d;
  logic              ack0_q, ack0_d;
  logic              ack1_q, ack1_d;
  logic [DATA_W-1:0] rdata0_q, rdata0_d;
  logic [DATA_W-1:0] rdata1_q, rdata1_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              rw_q, rw_d;
  logic              en_q, en_d;
  logic              busy_q, busy_d;

  logic el0;
  logic el1;
  logic gnt1;

  // A port acked this cycle sits out one arbitration round.
  assign el0  = bus.req0 & ~ack0_q;
  assign el1  = bus.req1 & ~ack1_q;
  assign gnt1 = el1 & (~el0 | (RoundRobin & ~last_q));

  always_comb begin
    state_d  = state_q;
    port_d   = port_q;
    last_d   = last_q;
    ack0_d   = 1'b0;
    ack1_d   = 1'b0;
    rdata0_d = rdata0_q;
    rdata1_d = rdata1_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rw_d     = rw_q;
    en_d     = en_q;
    unique case (state_q)
      IDLE: begin
        if (el0 | el1) begin
          port_d  = gnt1;
          last_d  = gnt1;
          addr_d  = gnt1 ? bus.addr1 : bus.addr0;
          wdata_d = gnt1 ? bus.wdata1 : bus.wdata0;
          rw_d    = gnt1 ? ~bus.we1 : ~bus.we0;
          en_d    = 1'b1;
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        en_d = 1'b0;
        rw_d = 1'b1;
        if (!rw_q) begin
          ack0_d  = ~port_q;
          ack1_d  = port_q;
          state_d = IDLE;
        end else begin
          state_d = CAPTURE;
        end
      end
      CAPTURE: begin
        if (port_q) begin
          rdata1_d = sram_rdata_i;
          ack1_d   = 1'b1;
        end else begin
          rdata0_d = sram_rdata_i;
          ack0_d   = 1'b1;
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      port_q   <= 1'b0;
      last_q   <= 1'b1;
      ack0_q   <= 1'b0;
      ack1_q   <= 1'b0;
      rdata0_q <= '0;
      rdata1_q <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rw_q     <= 1'b1;
      en_q     <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      port_q   <= port_d;
      last_q   <= last_d;
      ack0_q   <= ack0_d;
      ack1_q   <= ack1_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rw_q     <= rw_d;
      en_q     <= en_d;
      busy_q   <= busy_d;
    end
  end

  assign bus.ack0     = ack0_q;
  assign bus.ack1     = ack1_q;
  assign bus.rdata0   = rdata0_q;
  assign bus.rdata1   = rdata1_q;
  assign busy_o       = busy_q;
  assign sram_addr_o  = addr_q;
  assign sram_wdata_o = wdata_q;
  assign sram_rw_o    = rw_q;
  assign sram_en_o    = en_q;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Bench for sram_port_arbiter: round-robin and fixed-priority instances,
// each with a behavioural SRAM (registered read, z when not reading).
module tb_sram_port_arbiter;

  logic clk;
  logic rst;

  sram_port_arbiter_if #(.ADDR_W(13), .DATA_W(8)) bus_rr ();
  sram_port_arbiter_if #(.ADDR_W(13), .DATA_W(8)) bus_fp ();

  logic        busy_rr, rw_rr, en_rr;
  logic [12:0] addr_rr;
  logic [7:0]  wd_rr, rd_rr;
  logic        busy_fp, rw_fp, en_fp;
  logic [12:0] addr_fp;
  logic [7:0]  wd_fp, rd_fp;

  logic [7:0] mem_rr [8192];
  logic [7:0] mem_fp [8192];

  int n_checks;
  int n_fail;

  sram_port_arbiter #(.ADDR_W(13), .DATA_W(8), .FIXED_PRIO(0)) u_rr (
    .clk          (clk),
    .rst          (rst),
    .bus          (bus_rr.slave),
    .busy_o       (busy_rr),
    .sram_addr_o  (addr_rr),
    .sram_wdata_o (wd_rr),
    .sram_rw_o    (rw_rr),
    .sram_en_o    (en_rr),
    .sram_rdata_i (rd_rr)
  );

  sram_port_arbiter #(.ADDR_W(13), .DATA_W(8), .FIXED_PRIO(1)) u_fp (
    .clk          (clk),
    .rst          (rst),
    .bus          (bus_fp.slave),
    .busy_o       (busy_fp),
    .sram_addr_o  (addr_fp),
    .sram_wdata_o (wd_fp),
    .sram_rw_o    (rw_fp),
    .sram_en_o    (en_fp),
    .sram_rdata_i (rd_fp)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (en_rr && rw_rr) rd_rr <= mem_rr[addr_rr];
    else begin
      if (en_rr) mem_rr[addr_rr] <= wd_rr;
      rd_rr <= 'z;
    end
  end

  always @(posedge clk) begin
    if (en_fp && rw_fp) rd_fp <= mem_fp[addr_fp];
    else begin
      if (en_fp) mem_fp[addr_fp] <= wd_fp;
      rd_fp <= 'z;
    end
  end

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    bit          port;
    bit          we;
    logic [12:0] addr;
    logic [7:0]  wdata;
    int          lat;
    logic [7:0]  own_rd;
    logic [7:0]  oth_rd;
  } vec_t;

  vec_t tbl [7];

  // Single access on the RR instance; returns cycles from grant edge to ack.
  task automatic do_access(input bit port, input bit we,
                           input logic [12:0] addr, input logic [7:0] wd,
                           output int lat);
    bit got;
    got = 0;
    lat = 0;
    @(negedge clk);
    if (port) begin
      bus_rr.req1 = 1; bus_rr.we1 = we;
      bus_rr.addr1 = addr; bus_rr.wdata1 = wd;
    end else begin
      bus_rr.req0 = 1; bus_rr.we0 = we;
      bus_rr.addr0 = addr; bus_rr.wdata0 = wd;
    end
    for (int c = 1; c <= 10 && !got; c++) begin
      @(posedge clk); #1;
      if ((port ? bus_rr.ack1 : bus_rr.ack0) === 1'b1) begin
        got = 1;
        lat = c;
      end
    end
    if (!got) begin
      n_checks++;
      n_fail++;
      $display("FAIL access_timeout: got no ack expected ack");
    end
    bus_rr.req0 = 0;
    bus_rr.req1 = 0;
    @(posedge clk);
  endtask

  int lat;
  int ack_port [4];
  int ack_cyc  [4];
  int na;

  initial begin
    n_checks = 0;
    n_fail   = 0;
    clk = 0;
    rst = 1;
    {bus_rr.req0, bus_rr.req1, bus_rr.we0, bus_rr.we1} = '0;
    {bus_rr.addr0, bus_rr.addr1, bus_rr.wdata0, bus_rr.wdata1} = '0;
    {bus_fp.req0, bus_fp.req1, bus_fp.we0, bus_fp.we1} = '0;
    {bus_fp.addr0, bus_fp.addr1, bus_fp.wdata0, bus_fp.wdata1} = '0;

    tbl[0] = '{0, 1, 13'h1FFF, 8'hA5, 2, 8'h00, 8'h00};
    tbl[1] = '{0, 0, 13'h1FFF, 8'h00, 3, 8'hA5, 8'h00};
    tbl[2] = '{1, 1, 13'h0000, 8'h3C, 2, 8'h00, 8'hA5};
    tbl[3] = '{0, 0, 13'h0000, 8'h00, 3, 8'h3C, 8'h00};
    tbl[4] = '{1, 0, 13'h1FFF, 8'h00, 3, 8'hA5, 8'h3C};
    tbl[5] = '{0, 1, 13'h0ABC, 8'h5A, 2, 8'h3C, 8'hA5};
    tbl[6] = '{1, 0, 13'h0ABC, 8'h00, 3, 8'h5A, 8'h3C};

    repeat (2) @(negedge clk);
    chk("rst_ack0", bus_rr.ack0, 0);
    chk("rst_ack1", bus_rr.ack1, 0);
    chk("rst_rdata0", bus_rr.rdata0, 0);
    chk("rst_rdata1", bus_rr.rdata1, 0);
    chk("rst_busy", busy_rr, 0);
    chk("rst_en", en_rr, 0);
    chk("rst_rw", rw_rr, 1);
    chk("rst_addr", addr_rr, 0);
    chk("rst_wdata", wd_rr, 0);
    rst = 0;
    repeat (2) @(posedge clk);
    #1 chk("idle_busy", busy_rr, 0);

    foreach (tbl[i]) begin
      do_access(tbl[i].port, tbl[i].we, tbl[i].addr, tbl[i].wdata, lat);
      chk($sformatf("v%0d_lat", i), lat, tbl[i].lat);
      chk($sformatf("v%0d_own_rd", i),
          tbl[i].port ? bus_rr.rdata1 : bus_rr.rdata0, tbl[i].own_rd);
      chk($sformatf("v%0d_oth_rd", i),
          tbl[i].port ? bus_rr.rdata0 : bus_rr.rdata1, tbl[i].oth_rd);
    end

    // Both reads held, last grant was port 1: expect 0,1,0,1 every 3 clk.
    @(negedge clk);
    bus_rr.req0 = 1; bus_rr.we0 = 0; bus_rr.addr0 = 13'h1FFF;
    bus_rr.req1 = 1; bus_rr.we1 = 0; bus_rr.addr1 = 13'h0000;
    na = 0;
    for (int c = 1; c <= 20 && na < 4; c++) begin
      @(posedge clk); #1;
      if (bus_rr.ack0 && bus_rr.ack1) chk("rr_dual_ack", 1, 0);
      if (bus_rr.ack0 || bus_rr.ack1) begin
        ack_port[na] = bus_rr.ack1 ? 1 : 0;
        ack_cyc[na]  = c;
        if (bus_rr.ack0) chk("rr_rd0", bus_rr.rdata0, 8'hA5);
        else chk("rr_rd1", bus_rr.rdata1, 8'h3C);
        na++;
      end
    end
    bus_rr.req0 = 0;
    bus_rr.req1 = 0;
    chk("rr_nacks", na, 4);
    for (int k = 0; k < 4 && k < na; k++) begin
      chk($sformatf("rr_port%0d", k), ack_port[k], k % 2);
      chk($sformatf("rr_cyc%0d", k), ack_cyc[k], 3 * (k + 1));
    end
    @(posedge clk);

    // RR: after a port 0 grant, simultaneous requests go to port 1 first.
    do_access(0, 1, 13'h0100, 8'h77, lat);
    @(negedge clk);
    bus_rr.req0 = 1; bus_rr.we0 = 1;
    bus_rr.addr0 = 13'h0101; bus_rr.wdata0 = 8'h01;
    bus_rr.req1 = 1; bus_rr.we1 = 1;
    bus_rr.addr1 = 13'h0102; bus_rr.wdata1 = 8'h02;
    na = 0;
    for (int c = 1; c <= 20 && na < 2; c++) begin
      @(posedge clk); #1;
      if (bus_rr.ack0 || bus_rr.ack1) begin
        ack_port[na] = bus_rr.ack1 ? 1 : 0;
        ack_cyc[na]  = c;
        na++;
      end
    end
    bus_rr.req0 = 0;
    bus_rr.req1 = 0;
    chk("rr2_nacks", na, 2);
    if (na == 2) begin
      chk("rr2_first", ack_port[0], 1);
      chk("rr2_cyc0", ack_cyc[0], 2);
      chk("rr2_second", ack_port[1], 0);
      chk("rr2_cyc1", ack_cyc[1], 4);
    end
    @(posedge clk);

    // Fixed priority: port 0 wins, port 1 fills the masked cycle.
    @(negedge clk);
    bus_fp.req0 = 1; bus_fp.we0 = 1;
    bus_fp.addr0 = 13'h0005; bus_fp.wdata0 = 8'h55;
    for (int c = 1; c <= 10 && !bus_fp.ack0; c++) begin
      @(posedge clk); #1;
    end
    bus_fp.req0 = 0;
    chk("fp_pre_ack", bus_fp.ack0, 1);
    @(posedge clk);
    @(negedge clk);
    bus_fp.req0 = 1; bus_fp.addr0 = 13'h0010; bus_fp.wdata0 = 8'h11;
    bus_fp.req1 = 1; bus_fp.we1 = 1;
    bus_fp.addr1 = 13'h0020; bus_fp.wdata1 = 8'h22;
    na = 0;
    for (int c = 1; c <= 20 && na < 4; c++) begin
      @(posedge clk); #1;
      if (bus_fp.ack0 || bus_fp.ack1) begin
        ack_port[na] = bus_fp.ack1 ? 1 : 0;
        ack_cyc[na]  = c;
        na++;
      end
    end
    bus_fp.req0 = 0;
    bus_fp.req1 = 0;
    chk("fp_nacks", na, 4);
    for (int k = 0; k < 4 && k < na; k++) begin
      chk($sformatf("fp_port%0d", k), ack_port[k], k % 2);
      chk($sformatf("fp_cyc%0d", k), ack_cyc[k], 2 * (k + 1));
    end
    @(posedge clk); #1;
    chk("fp_mem10", mem_fp[16], 8'h11);
    chk("fp_mem20", mem_fp[32], 8'h22);

    // Reset while a write is in ACCESS.
    @(negedge clk);
    bus_rr.req0 = 1; bus_rr.we0 = 1;
    bus_rr.addr0 = 13'h0200; bus_rr.wdata0 = 8'hEE;
    @(posedge clk); #1;
    chk("rst_pre_en", en_rr, 1);
    chk("rst_pre_busy", busy_rr, 1);
    #2 rst = 1;
    #1;
    chk("rst_mid_en", en_rr, 0);
    chk("rst_mid_ack", bus_rr.ack0, 0);
    chk("rst_mid_busy", busy_rr, 0);
    chk("rst_mid_rw", rw_rr, 1);
    bus_rr.req0 = 0;
    @(negedge clk);
    rst = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_post_busy", busy_rr, 0);
    chk("rst_post_en", en_rr, 0);
    chk("rst_post_ack", bus_rr.ack0, 0);

    // Idle hold: read data survives 20 cycles of a floating SRAM bus.
    do_access(0, 0, 13'h1FFF, 8'h00, lat);
    do_access(1, 0, 13'h0000, 8'h00, lat);
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      chk("idle_en", en_rr, 0);
      chk("idle_rd0", bus_rr.rdata0, 8'hA5);
      chk("idle_rd1", bus_rr.rdata1, 8'h3C);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
